// File: rtl/fix_pkg.sv
// Shared FIX definitions: checksum-generator state encoding and protocol byte constants.
package fix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_DIG_H = 3'd2,
        ST_DIG_T = 3'd3,
        ST_DIG_U = 3'd4
    } chk_state_e;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] SOH        = 8'h01;
    localparam logic [7:0] EQ         = 8'h3d;

endpackage

// File: rtl/fix_checksum_gen_if.sv
// Byte-path interface between the FIX message creator (master) and the checksum generator (slave).
// The byte_count_o signal exists only when FIX_CHKSM_CNT_EN is defined.
interface fix_checksum_gen_if
`ifdef FIX_CHKSM_CNT_EN
    #(parameter int unsigned CNT_W = 16)
`endif
    ;

    logic       start_i;
    logic [7:0] byte_i;
    logic       byte_valid_i;
    logic       end_i;
    logic [7:0] checksum_val_o;
    logic       digit_valid_o;
    logic       done_o;
    logic       busy_o;
`ifdef FIX_CHKSM_CNT_EN
    logic [CNT_W-1:0] byte_count_o;

    modport master (
        output start_i, byte_i, byte_valid_i, end_i,
        input  checksum_val_o, digit_valid_o, done_o, busy_o, byte_count_o
    );

    modport slave (
        input  start_i, byte_i, byte_valid_i, end_i,
        output checksum_val_o, digit_valid_o, done_o, busy_o, byte_count_o
    );
`else
    modport master (
        output start_i, byte_i, byte_valid_i, end_i,
        input  checksum_val_o, digit_valid_o, done_o, busy_o
    );

    modport slave (
        input  start_i, byte_i, byte_valid_i, end_i,
        output checksum_val_o, digit_valid_o, done_o, busy_o
    );
`endif

endinterface

// File: rtl/fix_bin2ascii3.sv
// Combinational 8-bit binary to three ASCII decimal digits (hundreds, tens, units).
module fix_bin2ascii3
    import fix_pkg::*;
(
    input  logic [7:0] bin_i,
    output logic [7:0] hund_o,
    output logic [7:0] tens_o,
    output logic [7:0] unit_o
);

    always_comb begin
        hund_o = ASCII_ZERO + (bin_i / 8'd100);
        tens_o = ASCII_ZERO + ((bin_i / 8'd10) % 8'd10);
        unit_o = ASCII_ZERO + (bin_i % 8'd10);
    end

endmodule

// File: rtl/fix_checksum_gen.sv
// FIX tag-10 checksum generator: sums message bytes mod 256, excluding the trailing EXCL bytes,
// and returns the sum as three ASCII digits. Optional byte counter under FIX_CHKSM_CNT_EN.
module fix_checksum_gen
    import fix_pkg::*;
#(
    parameter int unsigned EXCL = 2
`ifdef FIX_CHKSM_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
    input logic             clk,
    input logic             rst,
    fix_checksum_gen_if.slave bus
);

    localparam int unsigned DLY_D    = (EXCL == 0) ? 1 : EXCL;
    localparam logic [2:0]  EXCL_OCC = 3'(EXCL);

    chk_state_e state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] final_q, final_d;
    logic [2:0] occ_q, occ_d;
    logic [7:0] dly_q [DLY_D];
    logic [7:0] dly_d [DLY_D];
    logic [7:0] val_q, val_d;
    logic       dv_q, dv_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;

    logic       restart;
    logic       byte_take;
    logic       add_en;
    logic [7:0] add_byte;
    logic [7:0] dig_h, dig_t, dig_u;

`ifdef FIX_CHKSM_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Converter sees final_d so the hundreds digit is ready on the cycle after end_i.
    fix_bin2ascii3 u_bin2ascii3 (
        .bin_i  (final_d),
        .hund_o (dig_h),
        .tens_o (dig_t),
        .unit_o (dig_u)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        final_d   = final_q;
        occ_d     = occ_q;
        dly_d     = dly_q;
        restart   = 1'b0;
        byte_take = 1'b0;
        add_en    = 1'b0;
        add_byte  = 8'h00;

        if (bus.start_i && (state_q inside {ST_IDLE, ST_ACCUM, ST_DIG_U})) begin
            restart = 1'b1;
            acc_d   = '0;
            occ_d   = '0;
            if (bus.end_i) begin
                final_d = '0;
                state_d = ST_DIG_H;
            end else begin
                state_d   = ST_ACCUM;
                byte_take = bus.byte_valid_i;
            end
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (bus.end_i) begin
                        final_d = acc_q;
                        state_d = ST_DIG_H;
                    end else begin
                        byte_take = bus.byte_valid_i;
                    end
                end
                ST_DIG_H: state_d = ST_DIG_T;
                ST_DIG_T: state_d = ST_DIG_U;
                ST_DIG_U: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end

        if (byte_take) begin
            if (EXCL == 0) begin
                add_en   = 1'b1;
                add_byte = bus.byte_i;
            end else begin
                if (occ_d == EXCL_OCC) begin
                    add_en   = 1'b1;
                    add_byte = dly_q[DLY_D-1];
                end else begin
                    occ_d = occ_d + 3'd1;
                end
                for (int unsigned i = DLY_D - 1; i > 0; i--) begin
                    dly_d[i] = dly_q[i-1];
                end
                dly_d[0] = bus.byte_i;
            end
        end

        if (add_en) begin
            acc_d = acc_d + add_byte;
        end

        case (state_d)
            ST_DIG_H: val_d = dig_h;
            ST_DIG_T: val_d = dig_t;
            ST_DIG_U: val_d = dig_u;
            default:  val_d = 8'h00;
        endcase
        dv_d   = state_d inside {ST_DIG_H, ST_DIG_T, ST_DIG_U};
        done_d = (state_d == ST_DIG_U);
        busy_d = (state_d != ST_IDLE);
    end

`ifdef FIX_CHKSM_CNT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end
        if (add_en && (cnt_d != '1)) begin
            cnt_d = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.byte_count_o = cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            final_q <= '0;
            occ_q   <= '0;
            for (int unsigned i = 0; i < DLY_D; i++) begin
                dly_q[i] <= '0;
            end
            val_q   <= '0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            final_q <= final_d;
            occ_q   <= occ_d;
            dly_q   <= dly_d;
            val_q   <= val_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.checksum_val_o = val_q;
    assign bus.digit_valid_o  = dv_q;
    assign bus.done_o         = done_q;
    assign bus.busy_o         = busy_q;

endmodule

// File: tb/tb_fix_checksum_gen.sv
// Directed self-checking bench for fix_checksum_gen (EXCL=2), hand-computed ASCII checksums.
module tb_fix_checksum_gen;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fix_checksum_gen_if bus ();

    fix_checksum_gen #(.EXCL(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Drive one cycle of inputs; return 1 time unit after the capturing edge.
    task automatic cyc(input logic s, input logic v, input logic [7:0] b, input logic e);
        bus.start_i      = s;
        bus.byte_valid_i = v;
        bus.byte_i       = b;
        bus.end_i        = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(0, 0, 8'h00, 0);
        cyc(1, 1, 8'h41, 0);
        checks++;
        if (bus.checksum_val_o !== 8'h00 || bus.digit_valid_o !== 1'b0 ||
            bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got val=%h dv=%b done=%b busy=%b exp 00 0 0 0",
                     bus.checksum_val_o, bus.digit_valid_o, bus.done_o, bus.busy_o);
        end
`ifdef FIX_CHKSM_CNT_EN
        checks++;
        if (bus.byte_count_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_count got %0d exp 0", bus.byte_count_o);
        end
`endif
        rst = 1'b0;
        cyc(0, 0, 8'h00, 0);
    endtask

    // "ABC" plus excluded "10" -> 198; inputs in DIG_H/DIG_T must be ignored.
    task automatic test_basic();
        logic [7:0] exp_d [3];
        exp_d = '{8'h31, 8'h39, 8'h38};
        cyc(1, 1, 8'h41, 0);
        checks++;
        if (bus.busy_o !== 1'b1 || bus.digit_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_accum_busy got busy=%b dv=%b exp 1 0", bus.busy_o, bus.digit_valid_o);
        end
        cyc(0, 1, 8'h42, 0);
        cyc(0, 1, 8'h43, 0);
        cyc(0, 1, 8'h31, 0);
        cyc(0, 1, 8'h30, 0);
        cyc(0, 1, 8'h77, 1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.checksum_val_o !== exp_d[k] || bus.digit_valid_o !== 1'b1 ||
                bus.done_o !== (k == 2) || bus.busy_o !== 1'b1) begin
                errors++;
                $display("FAIL basic_digit%0d got val=%h dv=%b done=%b busy=%b exp val=%h dv=1 done=%b busy=1",
                         k, bus.checksum_val_o, bus.digit_valid_o, bus.done_o, bus.busy_o, exp_d[k], k == 2);
            end
            if (k == 0)      cyc(1, 1, 8'hFF, 1);
            else if (k == 1) cyc(1, 1, 8'hFF, 0);
            else             cyc(0, 0, 8'h00, 0);
        end
        checks++;
        if (bus.checksum_val_o !== 8'h00 || bus.digit_valid_o !== 1'b0 ||
            bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle got val=%h dv=%b done=%b busy=%b exp 00 0 0 0",
                     bus.checksum_val_o, bus.digit_valid_o, bus.done_o, bus.busy_o);
        end
`ifdef FIX_CHKSM_CNT_EN
        checks++;
        if (bus.byte_count_o !== 16'd3) begin
            errors++;
            $display("FAIL basic_count got %0d exp 3", bus.byte_count_o);
        end
`endif
    endtask

    // 3 x 0xFF with a 3-cycle valid gap -> 765 mod 256 = 253.
    task automatic test_wrap_gap();
        logic [7:0] exp_d [3];
        exp_d = '{8'h32, 8'h35, 8'h33};
        cyc(1, 1, 8'hFF, 0);
        cyc(0, 1, 8'hFF, 0);
        cyc(0, 0, 8'hAA, 0);
        cyc(0, 0, 8'hAA, 0);
        cyc(0, 0, 8'hAA, 0);
        cyc(0, 1, 8'hFF, 0);
        cyc(0, 1, 8'h31, 0);
        cyc(0, 1, 8'h30, 0);
        cyc(0, 0, 8'h00, 1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.checksum_val_o !== exp_d[k] || bus.digit_valid_o !== 1'b1 || bus.done_o !== (k == 2)) begin
                errors++;
                $display("FAIL wrap_digit%0d got val=%h dv=%b done=%b exp val=%h dv=1 done=%b",
                         k, bus.checksum_val_o, bus.digit_valid_o, bus.done_o, exp_d[k], k == 2);
            end
            cyc(0, 0, 8'h00, 0);
        end
`ifdef FIX_CHKSM_CNT_EN
        checks++;
        if (bus.byte_count_o !== 16'd3) begin
            errors++;
            $display("FAIL wrap_count got %0d exp 3", bus.byte_count_o);
        end
`endif
    endtask

    task automatic test_start_end();
        cyc(1, 1, 8'h55, 1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.checksum_val_o !== 8'h30 || bus.digit_valid_o !== 1'b1 ||
                bus.busy_o !== 1'b1 || bus.done_o !== (k == 2)) begin
                errors++;
                $display("FAIL startend_digit%0d got val=%h dv=%b busy=%b done=%b exp 30 1 1 %b",
                         k, bus.checksum_val_o, bus.digit_valid_o, bus.busy_o, bus.done_o, k == 2);
            end
            cyc(0, 0, 8'h00, 0);
        end
        checks++;
        if (bus.busy_o !== 1'b0 || bus.digit_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL startend_idle got busy=%b dv=%b exp 0 0", bus.busy_o, bus.digit_valid_o);
        end
    endtask

    // Restart mid-message drops 0x10,0x20; 0x05+0x01 = 6.
    task automatic test_restart();
        logic [7:0] exp_d [3];
        exp_d = '{8'h30, 8'h30, 8'h36};
        cyc(1, 1, 8'h10, 0);
        cyc(0, 1, 8'h20, 0);
        cyc(1, 1, 8'h05, 0);
        cyc(0, 1, 8'h01, 0);
        cyc(0, 1, 8'h31, 0);
        cyc(0, 1, 8'h30, 0);
        cyc(0, 0, 8'h00, 1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.checksum_val_o !== exp_d[k] || bus.done_o !== (k == 2)) begin
                errors++;
                $display("FAIL restart_digit%0d got val=%h done=%b exp val=%h done=%b",
                         k, bus.checksum_val_o, bus.done_o, exp_d[k], k == 2);
            end
            cyc(0, 0, 8'h00, 0);
        end
`ifdef FIX_CHKSM_CNT_EN
        checks++;
        if (bus.byte_count_o !== 16'd2) begin
            errors++;
            $display("FAIL restart_count got %0d exp 2", bus.byte_count_o);
        end
`endif
    endtask

    task automatic test_rst_mid();
        cyc(1, 1, 8'h41, 0);
        cyc(0, 1, 8'h42, 0);
        cyc(0, 1, 8'h43, 0);
        cyc(0, 1, 8'h31, 0);
        cyc(0, 1, 8'h30, 0);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);
        checks++;
        if (bus.checksum_val_o !== 8'h39 || bus.digit_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_tens got val=%h dv=%b exp 39 1", bus.checksum_val_o, bus.digit_valid_o);
        end
        rst = 1'b1;
        cyc(0, 0, 8'h00, 0);
        checks++;
        if (bus.checksum_val_o !== 8'h00 || bus.digit_valid_o !== 1'b0 ||
            bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_cleared got val=%h dv=%b done=%b busy=%b exp 00 0 0 0",
                     bus.checksum_val_o, bus.digit_valid_o, bus.done_o, bus.busy_o);
        end
        rst = 1'b0;
        cyc(0, 0, 8'h00, 0);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.digit_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stay_idle got busy=%b dv=%b exp 0 0", bus.busy_o, bus.digit_valid_o);
        end
    endtask

    // Second message starts in DIG_U of the first: "005" then "009".
    task automatic test_back_to_back();
        logic [7:0] exp_a [3];
        logic [7:0] exp_b [3];
        exp_a = '{8'h30, 8'h30, 8'h35};
        exp_b = '{8'h30, 8'h30, 8'h39};
        cyc(1, 1, 8'h05, 0);
        cyc(0, 1, 8'h31, 0);
        cyc(0, 1, 8'h30, 0);
        cyc(0, 0, 8'h00, 1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.checksum_val_o !== exp_a[k] || bus.done_o !== (k == 2)) begin
                errors++;
                $display("FAIL b2b_a_digit%0d got val=%h done=%b exp val=%h done=%b",
                         k, bus.checksum_val_o, bus.done_o, exp_a[k], k == 2);
            end
            if (k < 2) cyc(0, 0, 8'h00, 0);
        end
        cyc(1, 1, 8'h07, 0);
        checks++;
        if (bus.busy_o !== 1'b1 || bus.digit_valid_o !== 1'b0 ||
            bus.checksum_val_o !== 8'h00 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accum got busy=%b dv=%b val=%h done=%b exp 1 0 00 0",
                     bus.busy_o, bus.digit_valid_o, bus.checksum_val_o, bus.done_o);
        end
        cyc(0, 1, 8'h02, 0);
        cyc(0, 1, 8'h31, 0);
        cyc(0, 1, 8'h30, 0);
        cyc(0, 0, 8'h00, 1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.checksum_val_o !== exp_b[k] || bus.done_o !== (k == 2)) begin
                errors++;
                $display("FAIL b2b_b_digit%0d got val=%h done=%b exp val=%h done=%b",
                         k, bus.checksum_val_o, bus.done_o, exp_b[k], k == 2);
            end
            cyc(0, 0, 8'h00, 0);
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = 8'h00;
        bus.end_i        = 1'b0;
        test_reset();
        test_basic();
        test_wrap_gap();
        test_start_end();
        test_restart();
        test_rst_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
